mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Sequencer that sits directly upstream of the 5-to-1 channel mux, driving its 3-bit select `{s2,s1,s0}`. It also sits downstream of the mux, sampling the mux output `m`. One scan frame steps the select through channels 0..4 (u, v, w, x, y), holds each for a programmable dwell time and captures `m` at the end of each dwell. At frame end it presents the five captured bits as one word with a completion pulse.

## Interface
- `DWELL`, default 4: cycles each channel select is held; legal range 1..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; sampled only in IDLE (and at frame end when `MUX_SCAN_CONT_EN` is compiled in).
- `m_in`  in  1  mux output `m`.
- `sel`  out  3  mux select `{s2,s1,s0}`; only codes 0..4 are ever driven.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at frame completion.
- `sample`  out  5  captured word; bit k = `m_in` captured while `sel`==k.

## Operation
- **FSM states:** IDLE, SCAN, DONE. All outputs are registered.
- **IDLE:**
  - Outputs: `sel`=0, `busy`=0, `done`=0.
  - `sample` holds its last frame value.
  - `start`=1 at an edge: go to SCAN with `sel`=0, dwell counter=0, `busy`=1.
- **SCAN, each edge:**
  - If dwell counter = DWELL-1: write `m_in` into the internal shadow bit [`sel`].
    - If `sel`=4: go to DONE and load `sample` with the shadow word, including the bit captured on this edge.
    - Otherwise: increment `sel` and clear the dwell counter.
  - Otherwise: increment the dwell counter.
- **DONE:**
  - Outputs: `done`=1, `busy`=0, `sel`=0.
  - Next edge goes to IDLE. The single-frame build ignores `start` here.
- **`start` while busy** (SCAN or DONE): ignored; it has no effect on `sel`, the counter or the shadow.
- **Partial frames:** `sample` never shows a partial frame. It changes only on the entry edge into DONE.
- **Counter width:** the dwell counter is max(1, clog2(DWELL)) bits. DWELL=1 captures on every SCAN edge.
- **Reset (async `rst_n`=0, any state):**
  - Outputs: `sel`=0, `busy`=0, `done`=0, `sample`=5'b00000.
  - Internal: shadow=0, dwell counter=0, state IDLE.
  - An aborted frame leaves no partial result.

## Timing
- **Frame timing:** let E0 be the edge that samples `start`=1 in IDLE.
  - Channel k is driven from edge E0+k·DWELL until edge E0+(k+1)·DWELL.
  - Capture of channel k happens on edge E0+(k+1)·DWELL. This gives the mux DWELL-1 full cycles of settle time before capture.
  - `done` and the new `sample` appear after edge E0+5·DWELL and are held for exactly one cycle of `done`.
  - `start`-to-`done` latency is 5·DWELL cycles. Minimum start-to-start repetition is 5·DWELL+2 edges.
- **Stability requirement:** `m_in` is treated as synchronous to `clk`. It must be stable on the capture edge.
- **Reset release:** first `start` can be sampled on the first edge after `rst_n` rises.

## Configuration
- Macro: `MUX_SCAN_CONT_EN`.
- **Defined (continuous mode):**
  - On the edge that enters DONE, if `start`=1, the FSM does not go to DONE. It re-enters SCAN with `sel`=0 and counter=0.
  - `done` pulses for one cycle, registered on that same edge. `sample` updates on that same edge.
  - `busy` stays 1 with no gap.
  - Frames repeat back-to-back every 5·DWELL cycles while `start` is held. When `start`=0 at a frame end, the FSM takes the normal DONE→IDLE path.
- **Undefined:** single-frame only, exactly as described in Operation.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame at sel=2 → `sel`=0, `busy`=0, `done`=0 and `sample`=00000 immediately (asynchronously). After release, `start`=1 gives a normal frame.
- **Single frame, DWELL=4:** drive `m_in` = (sel==1 || sel==3) → `busy` high for 20 cycles, `done` pulses at cycle 20 after E0, `sample`=5'b01010. `sel` visits 0,1,2,3,4, each for 4 cycles.
- **Start while busy:** pulse `start` again at cycle 7 of a frame with `m_in`=1 constant → frame unaffected, `done` at cycle 20, `sample`=5'b11111, no second frame.
- **DWELL=1 boundary:** `m_in` = (sel==4) → `sel` changes every cycle, `done` at cycle 5, `sample`=5'b10000.
- **Settle check:** DWELL=4, `m_in` follows the channel pattern but glitches to the inverse during the first 3 cycles of each channel → `sample` still equals the pattern (capture only on the last dwell edge).
- **`MUX_SCAN_CONT_EN` defined:** hold `start`=1 for 3 frames with `m_in`=sel[0] → `done` pulses at cycles 20, 40, 60, `busy` has no gap, `sample`=5'b01010 each frame. Drop `start` → IDLE after the third `done`.

Source files
------------

// File: rtl/mux_scan_if.sv
// Handshake/data bundle between a scan controller and the 5-to-1 channel mux.
// master: the side that requests scans and supplies the mux output m.
// slave : the scan controller itself.
interface mux_scan_if;
  logic       start;
  logic       m_in;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [4:0] sample;

  modport master (
    output start,
    output m_in,
    input  sel,
    input  busy,
    input  done,
    input  sample
  );

  modport slave (
    input  start,
    input  m_in,
    output sel,
    output busy,
    output done,
    output sample
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the 5-to-1 mux select through channels 0..4, holding
// each for DWELL cycles and capturing the mux output m on the last dwell edge.
// A full frame is published on `sample` together with a one-cycle `done`.
// Optional feature macro: MUX_SCAN_CONT_EN -- when defined, a `start` held
// high at frame end restarts the scan back-to-back without passing through
// DONE/IDLE (busy stays high, done still pulses).
module mux_scan_ctrl #(
  parameter int DWELL = 4  // cycles per channel, legal 1..16
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_scan_if.slave  bus
);

  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [2:0]    SEL_LAST = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    sel_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [4:0]    shadow_reg;
  logic [4:0]    sample_reg;
  logic [4:0]    shadow_next;

  // Shadow word with the bit for the current channel replaced by m_in, so
  // the last channel's capture lands in `sample` on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_shadow
      assign shadow_next[gi] = (sel_reg == 3'(gi)) ? bus.m_in : shadow_reg[gi];
    end
  endgenerate

  // Frame sequencer: state, dwell counter, select, capture and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sel_reg    <= 3'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      shadow_reg <= 5'd0;
      sample_reg <= 5'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          sel_reg  <= 3'd0;
          busy_reg <= 1'b0;
          if (bus.start) begin
            state_reg <= SCAN;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt_reg == CNT_LAST) begin
            shadow_reg <= shadow_next;
            cnt_reg    <= '0;
            if (sel_reg == SEL_LAST) begin
              sample_reg <= shadow_next;
              done_reg   <= 1'b1;
              sel_reg    <= 3'd0;
`ifdef MUX_SCAN_CONT_EN
              // Held start chains the next frame with no idle gap.
              if (!bus.start) begin
                state_reg <= DONE;
                busy_reg  <= 1'b0;
              end
`else
              state_reg <= DONE;
              busy_reg  <= 1'b0;
`endif
            end else begin
              sel_reg <= sel_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          state_reg <= IDLE;
          sel_reg   <= 3'd0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          sel_reg   <= 3'd0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel    = sel_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.sample = sample_reg;

endmodule
